// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit is held for OVERSAMPLE baud_clk cycles; all outputs are registered.
module uart_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       UART_TX,
    output logic       TX_STATUS,
    output logic       TX_DONE
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic LAST_STOP  = (STOP_BITS == 2);
    localparam logic PAR_ON     = (PARITY_EN != 0);
    localparam logic PAR_INVERT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              status_q, status_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              parity_bit;

    // The shift register rotates rather than shifts, so after eight data bits it
    // holds the original byte again; XOR is rotation-invariant anyway.
    assign bit_end    = (tick_q == TICK_LAST);
    assign parity_bit = (^shift_q) ^ PAR_INVERT;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        status_d = status_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
                if (TX_EN) begin
                    shift_d  = TX_DATA;
                    tick_d   = '0;
                    bit_d    = '0;
                    stop_d   = 1'b0;
                    tx_d     = 1'b0;
                    status_d = 1'b0;
                    state_d  = S_START;
                end
            end

            S_START: begin
                tick_d = tick_q + TICK_W'(1);
                if (bit_end) begin
                    tick_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                tick_d = tick_q + TICK_W'(1);
                if (bit_end) begin
                    tick_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[0], shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        if (PAR_ON) begin
                            tx_d    = parity_bit;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                tick_d = tick_q + TICK_W'(1);
                if (bit_end) begin
                    tick_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                tick_d = tick_q + TICK_W'(1);
                tx_d   = 1'b1;
                if (bit_end) begin
                    tick_d = '0;
                    if (stop_q == LAST_STOP) begin
                        status_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end

            default: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            status_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign UART_TX   = tx_q;
    assign TX_STATUS = status_q;
    assign TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations, per-instance line decoders acting as
// receivers, and a scoreboard of expected bytes per instance.
module tb_uart_transmitter;

    localparam int OS = 16;

    logic       clk;
    logic       rst;
    logic [7:0] td [4];
    logic [3:0] te;
    logic [3:0] tx;
    logic [3:0] st;
    logic [3:0] dn;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nfr [4];
    logic [7:0] exp_q [4][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Instance 0: defaults; 1: even parity; 2: odd parity; 3: two stop bits.
    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int PE = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        localparam int NB = 1 + 8 + PE + SB;

        uart_transmitter #(
            .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_EN(PE), .PARITY_ODD(PO)
        ) u_dut (
            .baud_clk (clk),
            .reset    (rst),
            .TX_DATA  (td[g]),
            .TX_EN    (te[g]),
            .UART_TX  (tx[g]),
            .TX_STATUS(st[g]),
            .TX_DONE  (dn[g])
        );

        initial begin : mon
            logic [NB-1:0] bits;
            logic          bad;
            logic          aborted;
            logic [7:0]    exp;
            logic          exp_b9;
            int            t0;
            nfr[g] = 0;
            forever begin
                @(negedge clk);
                if (tx[g] === 1'b0 && rst === 1'b0) begin
                    t0      = cyc;
                    bad     = 1'b0;
                    aborted = 1'b0;
                    bits    = '0;
                    for (int b = 0; b < NB && !aborted; b++) begin
                        for (int k = 0; k < OS && !aborted; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (rst) aborted = 1'b1;
                            else begin
                                if (k == 0) bits[b] = tx[g];
                                else if (tx[g] !== bits[b]) bad = 1'b1;
                                if (st[g] !== 1'b0 || dn[g] !== 1'b0) bad = 1'b1;
                            end
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        nfr[g]++;
                        check_eq($sformatf("done_pulse%0d", g), 32'(dn[g]), 32'd1);
                        check_eq($sformatf("status_done%0d", g), 32'(st[g]), 32'd1);
                        check_eq($sformatf("frame_len%0d", g), cyc - t0, OS * NB);
                        check_eq($sformatf("bit_shape%0d", g), 32'(bad), 32'd0);
                        check_eq($sformatf("stop_bits%0d", g), 32'(bits[NB-1] & bits[NB-SB]), 32'd1);
                        check_eq($sformatf("frame_expected%0d", g), 32'(exp_q[g].size() != 0), 32'd1);
                        if (exp_q[g].size() != 0) begin
                            exp    = exp_q[g].pop_front();
                            exp_b9 = (PE != 0) ? ((^exp) ^ (PO != 0)) : 1'b1;
                            check_eq($sformatf("rx_byte%0d", g), 32'(bits[8:1]), 32'(exp));
                            check_eq($sformatf("bit9_%0d", g), 32'(bits[9]), 32'(exp_b9));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        td[idx] = b;
        te[idx] = 1'b1;
        exp_q[idx].push_back(b);
        tick();
        te[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int limit);
        int n;
        n = 0;
        while (dn[idx] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check_eq($sformatf("done_timeout%0d", idx), 32'(dn[idx]), 32'd1);
    endtask

    initial begin
        int f0;
        int dseen;
        rst = 1'b1;
        te  = '0;
        for (int i = 0; i < 4; i++) td[i] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
            check_eq($sformatf("rst_status%0d", i), 32'(st[i]), 32'd1);
            check_eq($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
        end
        tick();

        // 0x55 on defaults: line low the cycle after acceptance.
        send(0, 8'h55);
        @(negedge clk);
        check_eq("latency_tx", 32'(tx[0]), 32'd0);
        check_eq("latency_status", 32'(st[0]), 32'd0);
        wait_done(0, 400);
        tick();
        @(negedge clk);
        check_eq("done_one_cycle", 32'(dn[0]), 32'd0);
        check_eq("idle_line", 32'(tx[0]), 32'd1);
        tick();

        // Request with different data in the middle of a 0xA3 frame is ignored.
        f0 = nfr[0];
        send(0, 8'hA3);
        repeat (49) tick();
        td[0] = 8'hFF;
        te[0] = 1'b1;
        tick();
        te[0] = 1'b0;
        wait_done(0, 400);
        repeat (200) tick();
        @(negedge clk);
        check_eq("no_queued_frame", nfr[0] - f0, 32'd1);
        check_eq("idle_status", 32'(st[0]), 32'd1);
        tick();

        // TX_EN held high: 0x12 then 0x34 back to back.
        td[0] = 8'h12;
        te[0] = 1'b1;
        exp_q[0].push_back(8'h12);
        exp_q[0].push_back(8'h34);
        tick();
        td[0] = 8'h34;
        wait_done(0, 400);
        check_eq("b2b_done_line", 32'(tx[0]), 32'd1);
        tick();
        te[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_start", 32'(tx[0]), 32'd0);
        check_eq("b2b_status", 32'(st[0]), 32'd0);
        wait_done(0, 400);
        tick();

        // Reset wins over a simultaneous request.
        rst   = 1'b1;
        td[0] = 8'h99;
        te[0] = 1'b1;
        tick();
        rst   = 1'b0;
        te[0] = 1'b0;
        @(negedge clk);
        check_eq("rst_prio_tx", 32'(tx[0]), 32'd1);
        check_eq("rst_prio_status", 32'(st[0]), 32'd1);
        repeat (4) tick();

        // Reset at cycle 80 of a frame aborts it without TX_DONE.
        td[0] = 8'hC4;
        te[0] = 1'b1;
        tick();
        te[0] = 1'b0;
        repeat (79) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_tx", 32'(tx[0]), 32'd1);
        check_eq("abort_status", 32'(st[0]), 32'd1);
        dseen = 0;
        for (int i = 0; i < 200; i++) begin
            if (dn[0] === 1'b1) dseen++;
            @(negedge clk);
        end
        check_eq("abort_no_done", dseen, 32'd0);
        tick();
        send(0, 8'h3C);
        wait_done(0, 400);
        tick();

        // Parity: 0x07 has odd weight, so even parity sends 1 and odd parity sends 0.
        send(1, 8'h07);
        send(2, 8'h07);
        wait_done(1, 400);
        wait_done(2, 400);
        tick();

        // Two stop bits, decoded by the bench receiver.
        send(3, 8'h00);
        wait_done(3, 400);
        tick();
        send(3, 8'hFF);
        wait_done(3, 400);
        tick();
        send(3, 8'h5A);
        wait_done(3, 400);
        repeat (20) tick();

        for (int i = 0; i < 4; i++)
            check_eq($sformatf("sb_empty%0d", i), exp_q[i].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
